mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single byte-wide RAM port between instruction fetch (IF) and the MEM stage.
//  Each 1/2/4-byte request is serialised into little-endian byte transfers by an FSM.
//  The returned word or load data is assembled before handing it back.
//  The ID-stage branch redirect (branch_enable_o) drives if_flush to abort a stale fetch.
// PARAMETERS
//  ADDR_WIDTH  32  width of if_addr, mem_addr and ram_a
//  RAM_LAT     1   cycles from ram_a valid to ram_din valid (reads)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   asynchronous, active-low reset
//  rdy        in   1   0 = pause: FSM, counters and all outputs hold
//  if_req     in   1   IF fetch request, level, held until if_done
//  if_addr    in   32  fetch address (4 bytes)
//  if_flush   in   1   branch redirect from ID; aborts/blocks the IF transaction
//  if_done    out  1   1-cycle pulse, if_inst valid
//  if_inst    out  32  assembled instruction
//  mem_req    in   1   MEM request, level, held until mem_done
//  mem_we     in   1   1 = store, 0 = load
//  mem_size   in   2   0 = byte, 1 = half, 2/3 = word
//  mem_addr   in   32  byte address
//  mem_wdata  in   32  store data (low bytes used)
//  mem_done   out  1   1-cycle pulse; mem_rdata valid for loads
//  mem_rdata  out  32  load data, zero-extended (MEM stage sign-extends)
//  ram_a      out  32  RAM byte address
//  ram_dout   out  8   RAM write byte
//  ram_wr     out  1   RAM write strobe
//  ram_din    in   8   RAM read byte
//  busy       out  1   state != IDLE; feeds the pipeline stall
// BEHAVIOUR
//  Reset: state = IDLE, byte counter = 0, every output = 0 (ram_wr = 0).
//  States:
//   - IDLE -> MEM_RD or MEM_WR when mem_req.
//   - IDLE -> IF_RD when if_req and no mem_req (fixed MEM priority).
//   - Busy states return to IDLE on the edge that raises done.
//  Grant sampling: requests are sampled only in IDLE, and only when no done pulse is high that cycle.
//   This gives one cooldown cycle so the requester can drop req.
//  Byte count n = 1/2/4 from mem_size; IF always n = 4.
//  Read (IF_RD, MEM_RD):
//   - ram_a = addr+k in cycle k, for k = 0..n-1 after the grant edge.
//   - Byte k is captured from ram_din RAM_LAT cycles later into bits [8k+7:8k].
//   - done rises n+RAM_LAT cycles after the grant. Unused upper bytes = 0.
//  Write (MEM_WR):
//   - cycle k: ram_a = addr+k, ram_dout = wdata[8k+7:8k], ram_wr = 1.
//   - mem_done rises n cycles after the grant; ram_wr = 0 in the done cycle.
//  Address arithmetic: addr+k wraps modulo 2^ADDR_WIDTH (0xFFFFFFFF+1 = 0).
//  Request capture: addr, size, we and wdata are latched at grant.
//   Later changes on the inputs are ignored until done.
//  if_flush:
//   - In IF_RD: abort, return to IDLE next edge, no if_done, if_inst unchanged.
//   - In IDLE with if_req the same cycle: the IF grant is suppressed.
//   - In MEM states: no effect.
//  MEM transactions are never preempted.
//  rdy = 0 mid-transaction: everything freezes; the transfer resumes at the same k when rdy = 1.
//  Reset mid-transaction: immediate return to IDLE, no done pulse.
//  done pulses last exactly one cycle. if_inst and mem_rdata hold until the next done.
// CONFIGURATION
//  MEM_ARBITER_FAIR_EN:
//   - Defined: a 1-bit flag is set on each MEM done. If the flag is set and if_req is high, the
//     next grant goes to IF even if mem_req is high. The flag clears on the IF grant or if_flush.
//   - Undefined: strict MEM priority; IF may starve under back-to-back MEM requests.
// TESTING
//  1. IF word: RAM[0..3]=13,00,00,00, if_req addr 0 -> ram_a 0..3; if_inst=0x00000013 with if_done at cycle 5.
//  2. SW 0xDEADBEEF @0x100 -> ram_wr 4 cycles, bytes EF,BE,AD,DE @0x100..0x103; mem_done at cycle 4.
//  3. LH @0x7 with RAM[7..8]=80,FF -> mem_rdata=0x0000FF80; mem_done at cycle 3.
//  4. if_req+mem_req together -> MEM first. Non-FAIR: IF grant after the cooldown cycle when
//     mem_req drops. FAIR: IF wins over an immediately re-asserted mem_req.
//  5. if_flush at cycle 2 of an IF read -> no if_done, busy=0 next cycle; new if_req @0x40 then
//     fetches 0x40..0x43.
//  6. rdy=0 for 3 cycles mid-LW -> ram_a held; done delayed by 3. rst=0 mid-store -> ram_wr=0 at once.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises IF fetches and MEM loads/stores onto one byte-wide RAM port.
// Define MEM_ARBITER_FAIR_EN to hand IF the next grant after every MEM completion.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int RAM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_done,
  output logic [31:0]           if_inst,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [1:0]            mem_size,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_done,
  output logic [31:0]           mem_rdata,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [7:0]            ram_dout,
  output logic                  ram_wr,
  input  logic [7:0]            ram_din,
  output logic                  busy
);
  localparam logic [1:0] IDLE = 2'd0, IF_RD = 2'd1, MEM_RD = 2'd2, MEM_WR = 2'd3;
  localparam logic [7:0] LAT = 8'(RAM_LAT);
  logic [1:0] state;
  logic [7:0] cnt, cnt_nx, nb, byte_k;
  logic [31:0] wdata_q, acc, merged;
  logic fair_win, idle_ok, grant_mem, grant_if, capture, last_rd, last_wr;
`ifdef MEM_ARBITER_FAIR_EN
  logic fair;
`endif
  always_comb begin
    cnt_nx = cnt + 8'd1;
    byte_k = cnt - LAT;
    capture = cnt >= LAT;
    merged = capture ? acc | (32'(ram_din) << (byte_k * 8'd8)) : acc;
    last_rd = cnt_nx == nb + LAT;
    last_wr = cnt_nx == nb;
`ifdef MEM_ARBITER_FAIR_EN
    fair_win = fair && if_req && !if_flush;
`else
    fair_win = 1'b0;
`endif
    // a done pulse still high means the requester has not yet dropped req
    idle_ok = state == IDLE && !if_done && !mem_done;
    grant_mem = idle_ok && mem_req && !fair_win;
    grant_if = idle_ok && if_req && !if_flush && (!mem_req || fair_win);
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      nb <= '0;
      wdata_q <= '0;
      acc <= '0;
      if_done <= 1'b0;
      if_inst <= '0;
      mem_done <= 1'b0;
      mem_rdata <= '0;
      ram_a <= '0;
      ram_dout <= '0;
      ram_wr <= 1'b0;
    end else if (rdy) begin
      if_done <= 1'b0;
      mem_done <= 1'b0;
      cnt <= cnt_nx;
      case (state)
        IDLE: begin
          cnt <= '0;
          acc <= '0;
          if (grant_mem) begin
            state <= mem_we ? MEM_WR : MEM_RD;
            ram_a <= mem_addr;
            nb <= mem_size == 2'd0 ? 8'd1 : mem_size == 2'd1 ? 8'd2 : 8'd4;
            wdata_q <= mem_wdata;
            ram_dout <= mem_wdata[7:0];
            ram_wr <= mem_we;
          end else if (grant_if) begin
            state <= IF_RD;
            ram_a <= if_addr;
            nb <= 8'd4;
          end
        end
        MEM_WR: begin
          if (last_wr) begin
            ram_wr <= 1'b0;
            mem_done <= 1'b1;
            state <= IDLE;
          end else begin
            ram_a <= ram_a + ADDR_WIDTH'(1);
            ram_dout <= 8'(wdata_q >> (cnt_nx * 8'd8));
          end
        end
        default: begin
          if (state == IF_RD && if_flush) state <= IDLE;
          else begin
            acc <= merged;
            if (cnt_nx < nb) ram_a <= ram_a + ADDR_WIDTH'(1);
            if (last_rd) begin
              state <= IDLE;
              if (state == IF_RD) begin
                if_done <= 1'b1;
                if_inst <= merged;
              end else begin
                mem_done <= 1'b1;
                mem_rdata <= merged;
              end
            end
          end
        end
      endcase
    end
  end
`ifdef MEM_ARBITER_FAIR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fair <= 1'b0;
    else if (rdy)
      fair <= ((state == MEM_RD && last_rd) || (state == MEM_WR && last_wr)) ? 1'b1 :
              (grant_if || if_flush) ? 1'b0 : fair;
  end
`endif
endmodule
